gf2_poly_div_465by233: RTL
==========================

# gf2_poly_div_465by233

Sequential GF(2) polynomial long divider, the inverse of the 233-bit Karatsuba multiplier. It divides a 465-bit product-width dividend by a 233-bit divisor and returns quotient and remainder, using carry-less (XOR) arithmetic. It sits beside the multiplier in the binary-field datapath. Uses include checking multiplier outputs, general modular reduction by non-fixed polynomials, and recovering an operand from a product. It processes one quotient bit per cycle with a start/done handshake.

## Interface
- No parameters; widths fixed (dividend 465, divisor 233).
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  465  numerator polynomial, bit i = coeff of x^i; captured on accepted start.
- divisor  input  233  denominator polynomial; captured on accepted start.
- busy  output  1  high from cycle after accepted start until done cycle (exclusive).
- done  output  1  one-cycle pulse; results valid from this cycle until next accepted start.
- quotient  output  465  registered quotient.
- remainder  output  233  registered remainder, degree < deg(divisor).
- div_by_zero  output  1  registered; set with done when captured divisor == 0.

## Operation
- States: IDLE, NORM, DIV, DENORM, DONE.
- IDLE: on start, capture W = dividend (465b working reg) and D = divisor (233b). Clear k (8b), quotient reg, and div_by_zero.
  - If divisor == 0: go to DONE with div_by_zero=1, quotient=0, remainder=0.
  - Else go to NORM.
- NORM, one cycle per step:
  - If D[232]=1, go to DIV with step counter = 233+k.
  - Else D <= D<<1 and k <= k+1.
  - k ends at 232-deg(divisor).
- DIV, one cycle per step:
  - If W[464]=1: W[464:232] ^= D and shift 1 into the quotient LSB; else shift 0.
  - Then W <= W<<1 (the XOR is applied before the shift, same cycle).
  - Decrement the step counter; at 0 go to DENORM.
  - Quotient register shifts left each step; after 233+k steps it holds the exact quotient, upper bits zero.
- DENORM: remainder reg R initialised from W[464:232], then shifted right by 1 per cycle for k+1 cycles. Then go to DONE.
- DONE: done=1 for one cycle, go to IDLE. Outputs hold their values.
- start during NORM/DIV/DENORM/DONE is ignored, with no queuing.
- Invariant: dividend == quotient·divisor XOR remainder (carry-less).

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE.
- Start accepted at edge E0 (start=1 in IDLE). busy=1 in cycles E0+1 .. E0+L-1; done=1 in cycle E0+L.
- Latency L = (k+1) + (233+k) + (k+1) + 1 = 3k+236, with k = 232-deg(divisor).
  - Range 236 (deg 232) to 932 (divisor=1).
- div_by_zero path: L = 1; busy never asserts.
- rst has priority over all events. If asserted mid-operation, the next cycle shows the reset values, and any in-flight result is discarded.
- start on the same edge as rst is ignored.
- start high in the done cycle is ignored. start must be presented in a later IDLE cycle; back-to-back throughput is one op per L+1 cycles.
- Outputs are registered only; no combinational input-to-output path.

## Configuration
- GF2DIV_QUOTIENT_EN:
  - Defined: quotient register and shift logic are present, and quotient is driven as specified.
  - Undefined: reduction-only build. The quotient register is removed and quotient is tied to 0. Remainder, div_by_zero, handshake and latency are identical.

## Test plan
- dividend=0x5 (x^2+1), divisor=0x3: quotient=0x3, remainder=0, div_by_zero=0, done at E0+929 (k=231).
- dividend = x^237+x^233+x^5+x (the product of a=x^232+1 and b=x^5+x), divisor=a: quotient=0x22, remainder=0, done at E0+236.
- dividend=0x7, divisor=0x3: quotient=0x2, remainder=0x1. Then divisor=1 with dividend=random R: quotient=R, remainder=0, done at E0+932.
- divisor=0, any dividend: done at E0+1, div_by_zero=1, quotient=0, remainder=0, busy stays 0.
- Start pulses during busy and in the done cycle are ignored, and results are unchanged. With rst asserted at E0+100, the next cycle shows busy=0, done=0 and all outputs 0; a fresh start then completes correctly.
- 1000 random (dividend, nonzero divisor) pairs: check dividend == quotient·divisor XOR remainder, deg(remainder) < deg(divisor), and L=3k+236. Repeat the run with GF2DIV_QUOTIENT_EN undefined: quotient==0 and remainder matches.

Source files
------------

// File: rtl/gf2_poly_div_465by233_if.sv
// Handshake and operand/result bundle for the 465-by-233 GF(2) polynomial divider.
// The master side issues start with operands; the slave side returns busy/done and results.
interface gf2_poly_div_465by233_if;
    logic         start;
    logic [464:0] dividend;
    logic [232:0] divisor;
    logic         busy;
    logic         done;
    logic [464:0] quotient;
    logic [232:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/gf2_poly_div_465by233.sv
// Sequential GF(2) long divider: 465-bit dividend by 233-bit divisor, one quotient bit per cycle.
// Macro GF2DIV_QUOTIENT_EN keeps the quotient register; without it the build is reduction-only.
module gf2_poly_div_465by233 (
    input  logic                      clk,
    input  logic                      rst,
    gf2_poly_div_465by233_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_DIV,
        S_DENORM,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [464:0] w_q, w_d;
    logic [232:0] d_q, d_d;
    logic [7:0]   k_q, k_d;
    logic [8:0]   cnt_q, cnt_d;
    logic [232:0] r_q, r_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         dbz_q, dbz_d;
`ifdef GF2DIV_QUOTIENT_EN
    logic [464:0] quot_q, quot_d;
`endif

    logic [464:0] w_step;
    logic [464:0] w_shift;

    // Subtract (XOR) the normalised divisor whenever the top coefficient is set, then advance.
    always_comb begin
        w_step  = w_q[464] ? (w_q ^ {d_q, 232'b0}) : w_q;
        w_shift = w_step << 1;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        d_d     = d_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef GF2DIV_QUOTIENT_EN
        quot_d  = quot_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    w_d   = bus.dividend;
                    d_d   = bus.divisor;
                    k_d   = 8'd0;
                    cnt_d = 9'd0;
                    r_d   = '0;
                    dbz_d = 1'b0;
`ifdef GF2DIV_QUOTIENT_EN
                    quot_d = '0;
`endif
                    if (bus.divisor == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_NORM;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_NORM: begin
                if (d_q[232]) begin
                    state_d = S_DIV;
                    cnt_d   = 9'd233 + {1'b0, k_q};
                end else begin
                    d_d = d_q << 1;
                    k_d = k_q + 8'd1;
                end
            end
            S_DIV: begin
                w_d = w_shift;
`ifdef GF2DIV_QUOTIENT_EN
                quot_d = {quot_q[463:0], w_q[464]};
`endif
                if (cnt_q == 9'd1) begin
                    // Remainder now sits at W[464:233+k]; DENORM slides it down by k+1.
                    state_d = S_DENORM;
                    cnt_d   = {1'b0, k_q};
                    r_d     = w_shift[464:232];
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            S_DENORM: begin
                r_d = r_q >> 1;
                if (cnt_q == 9'd0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef GF2DIV_QUOTIENT_EN
            quot_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            d_q     <= d_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef GF2DIV_QUOTIENT_EN
            quot_q  <= quot_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.remainder   = r_q;
    assign bus.div_by_zero = dbz_q;
`ifdef GF2DIV_QUOTIENT_EN
    assign bus.quotient    = quot_q;
`else
    assign bus.quotient    = '0;
`endif

endmodule
